// File: rtl/boxcar_trigger.sv
// Running boxcar sum with a threshold trigger and a holdoff FSM.
// Define BOXCAR_TRIGGER_ABS_EN to compare |sum| (one extra registered stage) instead of the signed sum.
module boxcar_trigger #(
    parameter int NSAMP   = 1,
    parameter int NBITS   = 14,
    parameter int SUMBITS = 24,
    parameter int PRIME   = 40
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NBITS*NSAMP-1:0]   dat_i,
    input  logic [NBITS*NSAMP-1:0]   dly_i,
    input  logic [SUMBITS-1:0]       thresh_i,
    input  logic [15:0]              holdoff_i,
    input  logic                     trig_en_i,
    output logic [SUMBITS-1:0]       sum_o,
    output logic                     trig_o,
    output logic                     armed_o
);

    localparam int PCW = (PRIME > 1) ? $clog2(PRIME) : 1;
    localparam logic [PCW-1:0] PRIME_LAST = PCW'(PRIME - 1);

    typedef enum logic [1:0] {
        ST_PRIME,
        ST_ARMED,
        ST_HOLD
    } state_t;

    logic [NBITS:0]   diff_q [NSAMP];
    logic [SUMBITS-1:0] diff_sum;
    logic [SUMBITS-1:0] s2_q;
    logic [SUMBITS-1:0] sum_q;
    logic [SUMBITS-1:0] cmp_val;
    logic               hit;

    state_t             state;
    logic [PCW-1:0]     prime_cnt;
    logic [15:0]        hold_cnt;
    logic               trig_q;
    logic               armed_q;

    // S1: per-lane difference, one bit wider than a sample so it cannot overflow.
    // NOTE: the lane array is a bank of pipeline flops, not a RAM, so it is reset with the rest.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NSAMP; i++) diff_q[i] <= '0;
        end else begin
            for (int i = 0; i < NSAMP; i++) begin
                // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
                diff_q[i] <= {dat_i[NBITS*i+NBITS-1], dat_i[NBITS*i +: NBITS]}
                           - {dly_i[NBITS*i+NBITS-1], dly_i[NBITS*i +: NBITS]};
            end
        end
    end

    // NOTE: the accumulator gets a default before the loop, so no latch is inferred.
    always_comb begin
        diff_sum = '0;
        for (int i = 0; i < NSAMP; i++) begin
            diff_sum = diff_sum + {{(SUMBITS-NBITS-1){diff_q[i][NBITS]}}, diff_q[i]};
        end
    end

    // S2 registers the lane total; S3 accumulates it, wrapping modulo 2^SUMBITS.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_q  <= '0;
            sum_q <= '0;
        end else begin
            s2_q  <= diff_sum;
            sum_q <= sum_q + s2_q;
        end
    end

    assign sum_o = sum_q;

`ifdef BOXCAR_TRIGGER_ABS_EN
    localparam logic [SUMBITS-1:0] MOST_NEG = {1'b1, {(SUMBITS-1){1'b0}}};
    localparam logic [SUMBITS-1:0] MOST_POS = {1'b0, {(SUMBITS-1){1'b1}}};

    logic [SUMBITS-1:0] abs_q;

    // Most-negative has no positive twin, so it saturates to the largest positive value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            abs_q <= '0;
        end else if (sum_q == MOST_NEG) begin
            abs_q <= MOST_POS;
        end else if (sum_q[SUMBITS-1]) begin
            abs_q <= -sum_q;
        end else begin
            abs_q <= sum_q;
        end
    end

    assign cmp_val = abs_q;
`else
    assign cmp_val = sum_q;
`endif

    assign hit = $signed(cmp_val) > $signed(thresh_i);

    // Holdoff FSM; holdoff_i is captured only at the firing edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_PRIME;
            prime_cnt <= '0;
            hold_cnt  <= '0;
            trig_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            case (state)
                ST_PRIME: begin
                    if (prime_cnt == PRIME_LAST) begin
                        state   <= ST_ARMED;
                        armed_q <= 1'b1;
                    end else begin
                        prime_cnt <= prime_cnt + PCW'(1);
                    end
                end
                ST_ARMED: begin
                    if (hit && trig_en_i) begin
                        trig_q   <= 1'b1;
                        state    <= ST_HOLD;
                        hold_cnt <= holdoff_i;
                        armed_q  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == 16'd0) begin
                        state   <= ST_ARMED;
                        armed_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 16'd1;
                    end
                end
                default: begin
                    state   <= ST_PRIME;
                    armed_q <= 1'b0;
                end
            endcase
        end
    end

    assign trig_o  = trig_q;
    assign armed_o = armed_q;

endmodule

// File: tb/tb_boxcar_trigger.sv
// Scoreboard bench for boxcar_trigger: a predictor derives the expected sum/trigger/armed
// per edge from cumulative sample history and trigger timing rules; a monitor compares.
module tb_boxcar_trigger;

    localparam int NS = 4;
    localparam int NB = 14;
    localparam int SB = 24;
    localparam int PR = 40;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NB*NS-1:0]  dat;
    logic [NB*NS-1:0]  dly;
    logic [SB-1:0]     thresh;
    logic [15:0]       holdoff;
    logic              en;
    logic [SB-1:0]     sum;
    logic              trig;
    logic              armed;

    typedef struct {
        longint s;
        bit     t;
        bit     a;
    } exp_t;

    exp_t   exp_q[$];
    int     total = 0;
    int     bad   = 0;

    boxcar_trigger #(.NSAMP(NS), .NBITS(NB), .SUMBITS(SB), .PRIME(PR)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .dat_i    (dat),
        .dly_i    (dly),
        .thresh_i (thresh),
        .holdoff_i(holdoff),
        .trig_en_i(en),
        .sum_o    (sum),
        .trig_o   (trig),
        .armed_o  (armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic longint wrap(input longint v);
        logic signed [SB-1:0] t;
        t = v[SB-1:0];
        return longint'(t);
    endfunction

    function automatic longint abs_sat(input longint v);
        if (v == -(longint'(1) << (SB-1))) return (longint'(1) << (SB-1)) - 1;
        return (v < 0) ? -v : v;
    endfunction

    // Reference: after edge k the sum holds every delta captured up to edge k-2.
    longint cum[$];
    int     c;
    int     last_trig;
    int     last_hold;
    bit     have_last;

    function automatic longint sum_after(input int k);
        return (k >= 2) ? wrap(cum[k-2]) : 0;
    endfunction

    initial begin : predictor
        exp_t   e;
        longint delta;
        longint v;
        bit     fire;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                c = 0;
                cum = {0};
                have_last = 1'b0;
                e = '{s: 0, t: 1'b0, a: 1'b0};
            end else begin
                c++;
                delta = 0;
                for (int i = 0; i < NS; i++) begin
                    delta += longint'($signed(dat[NB*i +: NB])) - longint'($signed(dly[NB*i +: NB]));
                end
                cum.push_back(cum[c-1] + delta);
`ifdef BOXCAR_TRIGGER_ABS_EN
                v = abs_sat(sum_after(c - 2));
`else
                v = sum_after(c - 1);
`endif
                fire = en && (v > longint'($signed(thresh))) && (c - 1 >= PR)
                       && (!have_last || (c - last_trig >= last_hold + 2));
                if (fire) begin
                    have_last = 1'b1;
                    last_trig = c;
                    last_hold = int'(holdoff);
                end
                e.s = sum_after(c);
                e.t = fire;
                e.a = (c >= PR) && !fire && (!have_last || (c >= last_trig + last_hold + 1));
            end
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("sum", longint'($signed(sum)), e.s);
                check("trig", longint'(trig), longint'(e.t));
                check("armed", longint'(armed), longint'(e.a));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_lanes(input int dv, input int lv);
        for (int i = 0; i < NS; i++) begin
            dat[NB*i +: NB] = dv[NB-1:0];
            dly[NB*i +: NB] = lv[NB-1:0];
        end
    endtask

    task automatic impulse(input int dv, input int lv, input int settle);
        set_lanes(dv, lv);
        step(1);
        set_lanes(0, 0);
        step(settle);
    endtask

    initial begin : stimulus
        rst_n   = 1'b0;
        dat     = '0;
        dly     = '0;
        thresh  = '0;
        holdoff = 16'd0;
        en      = 1'b1;
        #1;
        check("reset_sum", longint'(sum), 0);
        check("reset_trig", longint'(trig), 0);
        check("reset_armed", longint'(armed), 0);
        step(3);
        rst_n = 1'b1;

        // Matched streams: sum stays zero, nothing fires, arms after PRIME edges.
        set_lanes(100, 100);
        step(200);
        set_lanes(0, 0);
        step(5);

        // Sustained hit above 3999 with holdoff 10, holdoff changed mid-hold.
        thresh  = SB'(3999);
        holdoff = 16'd10;
        impulse(1000, 0, 6);
        holdoff = 16'd3;
        step(30);
        holdoff = 16'd10;
        step(30);
        impulse(0, 1000, 20);

        // Equality is not a hit.
        thresh = SB'(4000);
        impulse(1000, 0, 30);
        impulse(0, 1000, 20);

        // Disabled trigger holds off firing; re-enable fires.
        thresh = SB'(3999);
        holdoff = 16'd0;
        en = 1'b0;
        impulse(1000, 0, 30);
        en = 1'b1;
        step(20);
        impulse(0, 1000, 20);

        // Negative excursion: fires only with the absolute-value compare.
        impulse(-1000, 0, 30);
        impulse(1000, 0, 20);

        // Reset pulse in the middle of a holdoff.
        holdoff = 16'd20;
        impulse(1000, 0, 8);
        rst_n = 1'b0;
        #1;
        check("midhold_reset_sum", longint'(sum), 0);
        check("midhold_reset_trig", longint'(trig), 0);
        check("midhold_reset_armed", longint'(armed), 0);
        step(1);
        rst_n = 1'b1;
        step(10);
        impulse(1000, 0, 60);
        impulse(0, 1000, 10);

        // Randomised traffic with occasional parameter changes.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NS; i++) begin
                dat[NB*i +: NB] = NB'($urandom_range(0, (1 << NB) - 1));
                dly[NB*i +: NB] = NB'($urandom_range(0, (1 << NB) - 1));
            end
            if (n % 50 == 0) begin
                thresh  = SB'($urandom_range(0, 1 << 22)) - SB'(1 << 21);
                holdoff = 16'($urandom_range(0, 7));
                en      = ($urandom_range(0, 4) != 0);
            end
            step(1);
        end
        set_lanes(0, 0);
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
